// File: rtl/sig_pkg.sv
// Shared encodings for the multi-road signal controller.
package sig_pkg;

  typedef enum logic [1:0] {
    SIG_RED    = 2'd0,
    SIG_YELLOW = 2'd1,
    SIG_GREEN  = 2'd2
  } sig_e;

  typedef enum logic [2:0] {
    HWY_GREEN,
    HWY_YELLOW,
    ALL_RED,
    SIDE_GREEN,
    SIDE_YELLOW
  } state_e;

endpackage

// File: rtl/sig_timer.sv
// Loadable down-counter; done_c flags the last cycle of a loaded delay (0 loads as 1).
module sig_timer #(
  parameter int unsigned DELAY_W = 3
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               load,
  input  logic [DELAY_W-1:0] load_val,
  output logic               done_c
);

  logic [DELAY_W-1:0] count;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= (load_val == '0) ? DELAY_W'(1) : load_val;
    end else if (count != '0) begin
      count <= count - DELAY_W'(1);
    end
  end

  assign done_c = (count <= DELAY_W'(1));

endmodule

// File: rtl/multi_sig_controller.sv
// Highway / multi side-road signal controller with round-robin side arbitration
// and min/max green limits.
module multi_sig_controller
  import sig_pkg::*;
#(
  parameter int unsigned NUM_SIDE = 2,
  parameter int unsigned DELAY_W  = 3,
  localparam int unsigned IDX_W   = (NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [NUM_SIDE-1:0]   x,
  input  logic [DELAY_W-1:0]    y2rdelay,
  input  logic [DELAY_W-1:0]    r2gdelay,
  input  logic [DELAY_W-1:0]    mingreen,
  input  logic [DELAY_W-1:0]    maxgreen,
  output logic [1:0]            hwy,
  output logic [2*NUM_SIDE-1:0] side,
  output logic [IDX_W-1:0]      active_side
);

  state_e               state, state_next;
  logic [IDX_W-1:0]     last_served, last_next;
  logic [IDX_W-1:0]     grant_next, rr_grant;
  logic [DELAY_W-1:0]   green_cnt;
  logic [1:0]           hwy_next;
  logic [2*NUM_SIDE-1:0] side_next;
  logic                 timer_load, timer_done_c;
  logic [DELAY_W-1:0]   timer_val;
  logic                 rr_found, sel_req, min_done, max_done;
  int                   rr_idx;

  sig_timer #(.DELAY_W(DELAY_W)) u_timer (
    .clock    (clock),
    .clear    (clear),
    .load     (timer_load),
    .load_val (timer_val),
    .done_c   (timer_done_c)
  );

  // Round-robin search starting one past the last road served.
  always_comb begin
    rr_grant = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int k = 1; k <= int'(NUM_SIDE); k++) begin
      rr_idx = (int'(last_served) + k) % int'(NUM_SIDE);
      if (!rr_found && x[rr_idx]) begin
        rr_found = 1'b1;
        rr_grant = IDX_W'(rr_idx);
      end
    end
  end

  always_comb begin
    sel_req = 1'b0;
    for (int i = 0; i < int'(NUM_SIDE); i++) begin
      if (IDX_W'(i) == active_side) sel_req = x[i];
    end
  end

  // green_cnt holds completed cycles in the current green; this edge completes one more.
  assign min_done = (mingreen == '0) || (green_cnt >= mingreen - DELAY_W'(1));
  assign max_done = (maxgreen != '0) && (green_cnt >= maxgreen - DELAY_W'(1));

  always_comb begin
    state_next = state;
    grant_next = active_side;
    last_next  = last_served;
    timer_load = 1'b0;
    timer_val  = '0;
    hwy_next   = SIG_RED;
    side_next  = '0;

    unique case (state)
      HWY_GREEN: begin
        if (min_done && (x != '0)) begin
          state_next = HWY_YELLOW;
          grant_next = rr_grant;
          timer_load = 1'b1;
          timer_val  = y2rdelay;
        end
      end
      HWY_YELLOW: begin
        if (timer_done_c) begin
          state_next = ALL_RED;
          timer_load = 1'b1;
          timer_val  = r2gdelay;
        end
      end
      ALL_RED: begin
        if (timer_done_c) state_next = SIDE_GREEN;
      end
      SIDE_GREEN: begin
        if (!sel_req || max_done) begin
          state_next = SIDE_YELLOW;
          timer_load = 1'b1;
          timer_val  = y2rdelay;
        end
      end
      SIDE_YELLOW: begin
        if (timer_done_c) begin
          state_next = HWY_GREEN;
          last_next  = active_side;
        end
      end
      default: state_next = HWY_GREEN;
    endcase

    // Output decode of the upcoming state so the lamps are plain registers.
    if (state_next == HWY_GREEN)       hwy_next = SIG_GREEN;
    else if (state_next == HWY_YELLOW) hwy_next = SIG_YELLOW;
    for (int i = 0; i < int'(NUM_SIDE); i++) begin
      if (IDX_W'(i) == grant_next) begin
        if (state_next == SIDE_GREEN)       side_next[2*i +: 2] = SIG_GREEN;
        else if (state_next == SIDE_YELLOW) side_next[2*i +: 2] = SIG_YELLOW;
      end
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= HWY_GREEN;
      last_served <= IDX_W'(NUM_SIDE - 1);
      active_side <= '0;
      green_cnt   <= '0;
      hwy         <= SIG_GREEN;
      side        <= '0;
    end else begin
      state       <= state_next;
      last_served <= last_next;
      active_side <= grant_next;
      hwy         <= hwy_next;
      side        <= side_next;
      if (state_next != state)    green_cnt <= '0;
      else if (green_cnt != '1)   green_cnt <= green_cnt + DELAY_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_sig_controller.sv
// Randomized bench for multi_sig_controller against a phase-script reference model.
module tb_multi_sig_controller;

  localparam int unsigned NS = 2;
  localparam int unsigned DW = 3;
  localparam logic [1:0] C_R = 2'd0;
  localparam logic [1:0] C_Y = 2'd1;
  localparam logic [1:0] C_G = 2'd2;

  logic          clock = 1'b0;
  logic          clear;
  logic [NS-1:0] x;
  logic [DW-1:0] y2rdelay, r2gdelay, mingreen, maxgreen;
  logic [1:0]    hwy;
  logic [2*NS-1:0] side;
  logic [0:0]    active_side;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]      exp_hwy;
  logic [2*NS-1:0] exp_side;
  int              exp_act;

  multi_sig_controller #(.NUM_SIDE(NS), .DELAY_W(DW)) dut (
    .clock       (clock),
    .clear       (clear),
    .x           (x),
    .y2rdelay    (y2rdelay),
    .r2gdelay    (r2gdelay),
    .mingreen    (mingreen),
    .maxgreen    (maxgreen),
    .hwy         (hwy),
    .side        (side),
    .active_side (active_side)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic cycle();
    @(negedge clock);
    check("hwy", 32'(hwy), 32'(exp_hwy));
    check("side", 32'(side), 32'(exp_side));
    check("active_side", 32'(active_side), 32'(exp_act));
  endtask

  function automatic int eff(input logic [DW-1:0] d);
    return (d == '0) ? 1 : int'(d);
  endfunction

  task automatic m_tick(output bit ab);
    @(posedge clock);
    ab = clear;
  endtask

  task automatic m_hold(input int d, output bit ab);
    ab = 1'b0;
    for (int i = 0; i < d; i++) begin
      m_tick(ab);
      if (ab) break;
    end
  endtask

  // Reference: walk the signal cycle as a sequential script; any clear restarts it.
  initial begin : ref_model
    bit ab;
    int n, g, r, last;
    forever begin
      exp_hwy = C_G; exp_side = '0; exp_act = 0; last = NS - 1;
      forever begin
        n = 0;
        while (1) begin
          m_tick(ab);
          if (ab) break;
          n++;
          if (n >= eff(mingreen) && x != '0) break;
        end
        if (ab) break;
        g = -1;
        for (int k = 1; k <= int'(NS); k++) begin
          r = (last + k) % int'(NS);
          if (g < 0 && x[r]) g = r;
        end
        exp_act = g;
        exp_hwy = C_Y;
        m_hold(eff(y2rdelay), ab);
        if (ab) break;
        exp_hwy = C_R;
        m_hold(eff(r2gdelay), ab);
        if (ab) break;
        exp_side = '0;
        exp_side[2*g +: 2] = C_G;
        n = 0;
        while (1) begin
          m_tick(ab);
          if (ab) break;
          n++;
          if (!x[g] || (maxgreen != '0 && n >= int'(maxgreen))) break;
        end
        if (ab) break;
        exp_side[2*g +: 2] = C_Y;
        m_hold(eff(y2rdelay), ab);
        if (ab) break;
        exp_hwy = C_G; exp_side = '0; last = g;
      end
    end
  end

  task automatic async_clear(input string tag);
    #2 clear = 1'b1;
    #1;
    check({tag, "_hwy"}, 32'(hwy), 32'(C_G));
    check({tag, "_side"}, 32'(side), 32'd0);
    check({tag, "_act"}, 32'(active_side), 32'd0);
    cycle();
    clear = 1'b0;
  endtask

  initial begin
    bit reached;
    clear = 1'b1; x = '0;
    y2rdelay = 3'd3; r2gdelay = 3'd2; mingreen = 3'd4; maxgreen = 3'd0;
    cycle();
    check("rst_hwy", 32'(hwy), 32'(C_G));
    check("rst_side", 32'(side), 32'd0);
    check("rst_act", 32'(active_side), 32'd0);
    clear = 1'b0; x = 2'b01;

    // single requester held, then released
    repeat (12) cycle();
    x = 2'b00;
    repeat (10) cycle();
    // both roads requesting: alternation
    x = 2'b11;
    repeat (60) cycle();
    // max green cap
    maxgreen = 3'd5; x = 2'b01;
    repeat (40) cycle();
    maxgreen = 3'd0; x = 2'b00;
    repeat (12) cycle();

    // clear in the middle of a side-1 green
    x = 2'b10; reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      cycle();
      if (exp_side[3:2] == C_G) reached = 1'b1;
    end
    check("reach_side1_green", 32'(reached), 32'd1);
    async_clear("mid_green_clear");

    // zero yellow with a one-cycle request pulse on road 1
    x = 2'b00; y2rdelay = 3'd0;
    clear = 1'b1; cycle(); clear = 1'b0;
    repeat (3) cycle();
    x = 2'b10;
    cycle();
    x = 2'b00;
    repeat (15) cycle();

    // yellow delay changed while highway yellow is running
    y2rdelay = 3'd3; x = 2'b01; reached = 1'b0;
    for (int i = 0; i < 40 && !reached; i++) begin
      cycle();
      if (exp_hwy == C_Y) reached = 1'b1;
    end
    check("reach_hwy_yellow", 32'(reached), 32'd1);
    y2rdelay = 3'd6;
    repeat (8) cycle();
    x = 2'b00;
    repeat (20) cycle();
    y2rdelay = 3'd3;

    // random traffic, delays and clears
    for (int i = 0; i < 900; i++) begin
      cycle();
      if ($urandom_range(0, 3) == 0) x = NS'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) y2rdelay = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) r2gdelay = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) mingreen = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) maxgreen = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 99) == 0) async_clear("rand_clear");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
